// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: MDOp encodings,
// default busy durations (also consumed by hazard/stall logic and the ID
// decoder), FSM state type and the {HI,LO} result payload.
package md_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
//   SrcA, SrcB : forwarded operands (rs, rt)
//   MDOp       : operation select, valid with start
//   start      : one-cycle request
//   busy       : multi-cycle operation in progress
//   HI, LO     : architectural HI/LO registers
interface mult_div_unit_if;
  import md_pkg::*;

  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic [2:0]      MDOp;
  logic            start;
  logic            busy;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;

  modport master (output SrcA, SrcB, MDOp, start, input busy, HI, LO);
  modport slave  (input SrcA, SrcB, MDOp, start, output busy, HI, LO);
endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
//   src_a_i, src_b_i : operands
//   md_op_i          : operation select
//   result_o         : {HI,LO} result for MULT/MULTU/DIV/DIVU, zero otherwise
//   div_by_zero_o    : DIV/DIVU with a zero divisor
module md_arith
  import md_pkg::*;
(
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [2:0]      md_op_i,
  output md_result_t      result_o,
  output logic            div_by_zero_o
);

  logic                   is_div;
  logic                   div_ovf;
  logic [XLEN-1:0]        div_s_b;
  logic [XLEN-1:0]        div_u_b;
  logic signed [XLEN-1:0] q_s;
  logic signed [XLEN-1:0] r_s;
  logic [XLEN-1:0]        q_u;
  logic [XLEN-1:0]        r_u;
  logic signed [2*XLEN-1:0] p_s;
  logic [2*XLEN-1:0]      p_u;

  always_comb begin
    is_div        = (md_op_i == MD_DIV) || (md_op_i == MD_DIVU);
    div_by_zero_o = is_div && (src_b_i == '0);
    div_ovf       = (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);

    // Signed divisor becomes 1 for /0 (result discarded) and for MIN/-1,
    // where MIN/1 is exactly the required quotient/remainder.
    div_s_b = ((src_b_i == '0) || div_ovf) ? XLEN'(1) : src_b_i;
    div_u_b = (src_b_i == '0) ? XLEN'(1) : src_b_i;

    q_s = $signed(src_a_i) / $signed(div_s_b);
    r_s = $signed(src_a_i) % $signed(div_s_b);
    q_u = src_a_i / div_u_b;
    r_u = src_a_i % div_u_b;

    p_s = (2*XLEN)'($signed(src_a_i)) * (2*XLEN)'($signed(src_b_i));
    p_u = (2*XLEN)'(src_a_i) * (2*XLEN)'(src_b_i);

    result_o = '0;
    case (md_op_i)
      MD_MULT:  result_o = md_result_t'(p_s);
      MD_MULTU: result_o = md_result_t'(p_u);
      MD_DIV: begin
        result_o.hi = r_s;
        result_o.lo = q_s;
      end
      MD_DIVU: begin
        result_o.hi = r_u;
        result_o.lo = q_u;
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//   clk, reset_n : clock, asynchronous active-low reset
//   md           : slave side of the request/result bundle
// The result is computed at start and held in a pending register; busy
// models the iterative latency and the commit lands on the edge busy falls.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic           clk,
  input  logic           reset_n,
  mult_div_unit_if.slave md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_result_t      pend_q, pend_d;
  logic            skip_q, skip_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            busy_q;

  md_result_t      arith_res;
  logic            arith_dz;

  md_arith u_arith (
    .src_a_i       (md.SrcA),
    .src_b_i       (md.SrcB),
    .md_op_i       (md.MDOp),
    .result_o      (arith_res),
    .div_by_zero_o (arith_dz)
  );

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      skip_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      skip_q  <= skip_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d == ST_BUSY);
    end
  end

  // Next-state: accept requests in IDLE, count down and commit in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    skip_d  = skip_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          case (md.MDOp)
            MD_MULT, MD_MULTU: begin
              pend_d  = arith_res;
              skip_d  = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              pend_d  = arith_res;
              skip_d  = arith_dz;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = ST_BUSY;
            end
            MD_MTHI: hi_d = md.SrcA;
            MD_MTLO: lo_d = md.SrcA;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          // Divide by zero keeps the old HI/LO.
          if (!skip_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign md.busy = busy_q;
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule
